// File: rtl/adder_regbank_pkg.sv
// adder_regbank_pkg: register offsets, field bit positions and the
// per-channel handshake state type shared by the register bank files.
package adder_regbank_pkg;

  localparam logic [2:0] OFF_R0     = 3'd0;
  localparam logic [2:0] OFF_R1     = 3'd1;
  localparam logic [2:0] OFF_RES    = 3'd2;
  localparam logic [2:0] OFF_CTRL   = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;
  localparam logic [2:0] OFF_IRQEN  = 3'd5;

  localparam int CTRL_START = 0;
  localparam int CTRL_OP    = 1;
  localparam int ST_DONE    = 0;
  localparam int ST_OVR     = 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } ch_state_t;

endpackage

// File: rtl/adder_regbank_ch.sv
// adder_regbank_ch: one channel's R0/R1/RES/CTRL/STATUS(/IRQ_EN) registers
// and its start/ack/done handshake FSM toward the adder datapath.
// Ports: clk/rst, decoded write (wr_sel/off/data/strb), read (rd_off ->
// rd_data), busy, datapath handshake (start/ack/done_in/result), op/r0/r1.
// With ADDER_REGBANK_IRQ_EN an IRQ_EN register and irq_req are added.
module adder_regbank_ch
  import adder_regbank_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_sel,
  input  logic [2:0]          wr_off,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_strb,
  input  logic [2:0]          rd_off,
  output logic                busy,
  output logic                start,
  input  logic                ack,
  input  logic                done_in,
  input  logic [DATA_W-1:0]   result,
  output logic                op,
  output logic [DATA_W-1:0]   r0,
  output logic [DATA_W-1:0]   r1,
`ifdef ADDER_REGBANK_IRQ_EN
  output logic                irq_req,
`endif
  output logic [DATA_W-1:0]   rd_data
);

  localparam int SW = DATA_W / 8;

  ch_state_t         state, state_nx;
  logic [DATA_W-1:0] res;
  logic [DATA_W-1:0] bmask;
  logic              done_q, ovr_q;
  logic              wr_r0, wr_r1, wr_ctrl, wr_stat;
  logic              go, ovr_set, cap;

  always_comb begin
    bmask = '0;
    for (int b = 0; b < SW; b++)
      bmask[b*8 +: 8] = {8{wr_strb[b]}};
  end

  assign wr_r0   = wr_sel & (wr_off == OFF_R0) & ~busy;
  assign wr_r1   = wr_sel & (wr_off == OFF_R1) & ~busy;
  assign wr_ctrl = wr_sel & (wr_off == OFF_CTRL) & wr_strb[0];
  assign wr_stat = wr_sel & (wr_off == OFF_STATUS) & wr_strb[0];
  assign go      = wr_ctrl & ~busy & wr_data[CTRL_START];
  // A START attempt while busy is an overrun.
  assign ovr_set = wr_ctrl & busy & wr_data[CTRL_START];
  // Result is taken in WAIT on done, or in REQ when ack and done coincide.
  assign cap     = done_in & ((state == WAIT) |
                              ((state == REQ) & ack));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (go) state_nx = REQ;
      REQ: begin
        if (ack & done_in) state_nx = IDLE;
        else if (ack)      state_nx = WAIT;
      end
      WAIT: if (done_in) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    start = (state == REQ);
    busy  = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r0     <= '0;
      r1     <= '0;
      res    <= '0;
      op     <= 1'b0;
      done_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      if (wr_r0) r0 <= (r0 & ~bmask) | (wr_data & bmask);
      if (wr_r1) r1 <= (r1 & ~bmask) | (wr_data & bmask);
      if (wr_ctrl & ~busy) op <= wr_data[CTRL_OP];
      if (cap) res <= result;
      // Hardware set wins over a same-cycle W1C.
      done_q <= cap |
        (done_q & ~(wr_stat & wr_data[ST_DONE]));
      ovr_q <= ovr_set |
        (ovr_q & ~(wr_stat & wr_data[ST_OVR]));
    end
  end

`ifdef ADDER_REGBANK_IRQ_EN
  logic irq_en;

  always_ff @(posedge clk) begin
    if (rst)
      irq_en <= 1'b0;
    else if (wr_sel & (wr_off == OFF_IRQEN) & wr_strb[0])
      irq_en <= wr_data[0];
  end

  assign irq_req = done_q & irq_en;
`endif

  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      (rd_off == OFF_R0):  rd_data = r0;
      (rd_off == OFF_R1):  rd_data = r1;
      (rd_off == OFF_RES): rd_data = res;
      (rd_off == OFF_CTRL): begin
        rd_data[CTRL_START] = busy;
        rd_data[CTRL_OP]    = op;
      end
      (rd_off == OFF_STATUS): begin
        rd_data[ST_DONE] = done_q;
        rd_data[ST_OVR]  = ovr_q;
      end
`ifdef ADDER_REGBANK_IRQ_EN
      (rd_off == OFF_IRQEN): rd_data[0] = irq_en;
`endif
      default: rd_data = '0;
    endcase
  end

endmodule

// File: rtl/adder_regbank.sv
// adder_regbank: NUM_CH-channel register bank between the AMBA front end
// and the adder datapaths; word address = {channel, offset[2:0]}.
// Ports: ACLK/ARST, write (i_addr_wc/i_data_wc/i_strb_wc/i_en_amba_write,
// o_wr_err), read (i_addr_rc/o_data_rc/o_rd_err), per-channel handshake
// (o_start/i_ack/i_done/i_result) and operands (o_op/o_r0/o_r1), o_irq.
// Macro ADDER_REGBANK_IRQ_EN enables IRQ_EN registers and a live o_irq.
module adder_regbank
  import adder_regbank_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                     ACLK,
  input  logic                     ARST,
  input  logic [ADDR_W-1:0]        i_addr_wc,
  input  logic [DATA_W-1:0]        i_data_wc,
  input  logic [DATA_W/8-1:0]      i_strb_wc,
  input  logic                     i_en_amba_write,
  output logic                     o_wr_err,
  input  logic [ADDR_W-1:0]        i_addr_rc,
  output logic [DATA_W-1:0]        o_data_rc,
  output logic                     o_rd_err,
  output logic [NUM_CH-1:0]        o_start,
  input  logic [NUM_CH-1:0]        i_ack,
  input  logic [NUM_CH-1:0]        i_done,
  input  logic [NUM_CH*DATA_W-1:0] i_result,
  output logic [NUM_CH-1:0]        o_op,
  output logic [NUM_CH*DATA_W-1:0] o_r0,
  output logic [NUM_CH*DATA_W-1:0] o_r1,
  output logic                     o_irq
);

  localparam int CHW = ADDR_W - 3;
  localparam logic [CHW-1:0] NCH = CHW'(NUM_CH);

  logic [CHW-1:0]    wr_ch, rd_ch;
  logic [2:0]        wr_off, rd_off;
  logic [NUM_CH-1:0] wr_sel, busy;
  logic [DATA_W-1:0] rd_data [NUM_CH];
  logic              tgt_busy, wr_oor, wr_blk;

  assign wr_ch  = i_addr_wc[ADDR_W-1:3];
  assign wr_off = i_addr_wc[2:0];
  assign rd_ch  = i_addr_rc[ADDR_W-1:3];
  assign rd_off = i_addr_rc[2:0];

  always_comb begin
    wr_sel   = '0;
    tgt_busy = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_ch == CHW'(c)) begin
        wr_sel[c] = i_en_amba_write;
        tgt_busy  = busy[c];
      end
    end
  end

  assign wr_oor = (wr_ch >= NCH);
  assign wr_blk = tgt_busy &
    ((wr_off == OFF_R0) | (wr_off == OFF_R1) |
     (wr_off == OFF_CTRL));
  assign o_wr_err = i_en_amba_write &
    (wr_oor | (wr_off == OFF_RES) | wr_blk);

  always_comb begin
    o_data_rc = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (rd_ch == CHW'(c)) o_data_rc = rd_data[c];
  end

  assign o_rd_err = (rd_ch >= NCH);

`ifdef ADDER_REGBANK_IRQ_EN
  logic [NUM_CH-1:0] irq_vec;
  logic              irq_q;

  always_ff @(posedge ACLK) begin
    if (ARST) irq_q <= 1'b0;
    else      irq_q <= |irq_vec;
  end

  assign o_irq = irq_q;
`else
  assign o_irq = 1'b0;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    adder_regbank_ch #(
      .DATA_W(DATA_W)
    ) u_ch (
      .clk     (ACLK),
      .rst     (ARST),
      .wr_sel  (wr_sel[c]),
      .wr_off  (wr_off),
      .wr_data (i_data_wc),
      .wr_strb (i_strb_wc),
      .rd_off  (rd_off),
      .busy    (busy[c]),
      .start   (o_start[c]),
      .ack     (i_ack[c]),
      .done_in (i_done[c]),
      .result  (i_result[c*DATA_W +: DATA_W]),
      .op      (o_op[c]),
      .r0      (o_r0[c*DATA_W +: DATA_W]),
      .r1      (o_r1[c*DATA_W +: DATA_W]),
`ifdef ADDER_REGBANK_IRQ_EN
      .irq_req (irq_vec[c]),
`endif
      .rd_data (rd_data[c])
    );
  end

endmodule

// File: tb/tb_adder_regbank.sv
// tb_adder_regbank: table-driven register access vectors plus directed
// handshake, overrun, reset-abort and (with the macro) interrupt sequences.
module tb_adder_regbank;

  localparam int NUM_CH = 2;
  localparam int DW     = 32;
  localparam int AW     = 32;
`ifdef ADDER_REGBANK_IRQ_EN
  localparam logic [31:0] IRQV = 32'h1;
`else
  localparam logic [31:0] IRQV = 32'h0;
`endif

  logic                 ACLK = 1'b0;
  logic                 ARST;
  logic [AW-1:0]        i_addr_wc;
  logic [DW-1:0]        i_data_wc;
  logic [DW/8-1:0]      i_strb_wc;
  logic                 i_en_amba_write;
  logic                 o_wr_err;
  logic [AW-1:0]        i_addr_rc;
  logic [DW-1:0]        o_data_rc;
  logic                 o_rd_err;
  logic [NUM_CH-1:0]    o_start;
  logic [NUM_CH-1:0]    i_ack;
  logic [NUM_CH-1:0]    i_done;
  logic [NUM_CH*DW-1:0] i_result;
  logic [NUM_CH-1:0]    o_op;
  logic [NUM_CH*DW-1:0] o_r0;
  logic [NUM_CH*DW-1:0] o_r1;
  logic                 o_irq;

  int checks = 0;
  int errors = 0;

  always #5 ACLK = ~ACLK;

  adder_regbank #(
    .NUM_CH(NUM_CH), .DATA_W(DW), .ADDR_W(AW)
  ) dut (
    .ACLK(ACLK), .ARST(ARST),
    .i_addr_wc(i_addr_wc), .i_data_wc(i_data_wc),
    .i_strb_wc(i_strb_wc), .i_en_amba_write(i_en_amba_write),
    .o_wr_err(o_wr_err),
    .i_addr_rc(i_addr_rc), .o_data_rc(o_data_rc),
    .o_rd_err(o_rd_err),
    .o_start(o_start), .i_ack(i_ack), .i_done(i_done),
    .i_result(i_result), .o_op(o_op),
    .o_r0(o_r0), .o_r1(o_r1), .o_irq(o_irq)
  );

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] raddr;
    logic [31:0] exp_rd;
    logic        exp_werr;
    logic        exp_rerr;
  } vec_t;

  vec_t tv [11];

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // One committed write; werr is sampled during the commit cycle.
  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, output logic werr);
    i_addr_wc       = a;
    i_data_wc       = d;
    i_strb_wc       = s;
    i_en_amba_write = 1'b1;
    #1;
    werr = o_wr_err;
    tick();
    i_en_amba_write = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d,
                    output logic rerr);
    i_addr_rc = a;
    #1;
    d    = o_data_rc;
    rerr = o_rd_err;
  endtask

  logic [31:0] d;
  logic        e, we;

  initial begin
    ARST = 1'b1;
    i_addr_wc = '0; i_data_wc = '0; i_strb_wc = '0;
    i_en_amba_write = 1'b0; i_addr_rc = '0;
    i_ack = '0; i_done = '0; i_result = '0;
    tick(); tick();
    ARST = 1'b0;
    tick();

    for (int o = 0; o < 5; o++) begin
      rd(32'(o), d, e);
      check($sformatf("reset_rd_off%0d", o), 64'(d), 64'h0);
    end
    check("reset_start", 64'(o_start), 64'h0);
    check("reset_irq", 64'(o_irq), 64'h0);
    check("reset_op", 64'(o_op), 64'h0);

    tv[0]  = '{32'd0, 32'h11223344, 4'hF, 32'd0, 32'h11223344, 1'b0, 1'b0};
    tv[1]  = '{32'd0, 32'hAABBCCDD, 4'h2, 32'd0, 32'h1122CC44, 1'b0, 1'b0};
    tv[2]  = '{32'd1, 32'hDEADBEEF, 4'h9, 32'd1, 32'hDE0000EF, 1'b0, 1'b0};
    tv[3]  = '{32'd2, 32'h00000055, 4'hF, 32'd2, 32'h0, 1'b1, 1'b0};
    tv[4]  = '{32'd3, 32'h000000FE, 4'h1, 32'd3, 32'h2, 1'b0, 1'b0};
    tv[5]  = '{32'd3, 32'h000000FF, 4'h0, 32'd3, 32'h2, 1'b0, 1'b0};
    tv[6]  = '{32'd6, 32'h0000FFFF, 4'hF, 32'd6, 32'h0, 1'b0, 1'b0};
    tv[7]  = '{32'd5, 32'h00000003, 4'hF, 32'd5, IRQV, 1'b0, 1'b0};
    tv[8]  = '{32'd16, 32'h1, 4'hF, 32'd16, 32'h0, 1'b1, 1'b1};
    tv[9]  = '{32'd4, 32'h00000003, 4'h1, 32'd4, 32'h0, 1'b0, 1'b0};
    tv[10] = '{32'd7, 32'h00000001, 4'hF, 32'd7, 32'h0, 1'b0, 1'b0};

    for (int i = 0; i < 11; i++) begin
      wr(tv[i].waddr, tv[i].wdata, tv[i].strb, we);
      check($sformatf("vec%0d_werr", i), 64'(we), 64'(tv[i].exp_werr));
      rd(tv[i].raddr, d, e);
      check($sformatf("vec%0d_rd", i), 64'(d), 64'(tv[i].exp_rd));
      check($sformatf("vec%0d_rerr", i), 64'(e), 64'(tv[i].exp_rerr));
    end
    check("op0_out", 64'(o_op[0]), 64'h1);
    check("r0_ch0_out", 64'(o_r0[31:0]), 64'h1122CC44);

    // Channel 1 full transaction with overrun and busy-drop.
    wr(32'd8, 32'h5, 4'hF, we);
    wr(32'd9, 32'h3, 4'hF, we);
    check("r0_ch1_out", 64'(o_r0[63:32]), 64'h5);
    check("r1_ch1_out", 64'(o_r1[63:32]), 64'h3);
    wr(32'd11, 32'h1, 4'h1, we);
    check("ch1_start_req", 64'(o_start[1]), 64'h1);
    i_ack[1] = 1'b1;
    tick();
    i_ack[1] = 1'b0;
    check("ch1_start_after_ack", 64'(o_start[1]), 64'h0);
    rd(32'd11, d, e);
    check("ch1_ctrl_busy", 64'(d), 64'h1);
    wr(32'd11, 32'h1, 4'h1, we);
    check("ch1_ovr_werr", 64'(we), 64'h1);
    rd(32'd12, d, e);
    check("ch1_status_ovr", 64'(d), 64'h2);
    i_done[1] = 1'b1;
    i_result[63:32] = 32'd8;
    wr(32'd8, 32'h77, 4'hF, we);
    i_done[1] = 1'b0;
    check("ch1_busy_r0_werr", 64'(we), 64'h1);
    rd(32'd10, d, e);
    check("ch1_res", 64'(d), 64'h8);
    rd(32'd12, d, e);
    check("ch1_status_done_ovr", 64'(d), 64'h3);
    rd(32'd8, d, e);
    check("ch1_r0_kept", 64'(d), 64'h5);
    rd(32'd11, d, e);
    check("ch1_ctrl_idle", 64'(d), 64'h0);
    wr(32'd10, 32'hFF, 4'hF, we);
    check("ch1_res_werr", 64'(we), 64'h1);
    rd(32'd10, d, e);
    check("ch1_res_unchanged", 64'(d), 64'h8);
    wr(32'd12, 32'h3, 4'h1, we);
    rd(32'd12, d, e);
    check("ch1_status_w1c", 64'(d), 64'h0);

`ifdef ADDER_REGBANK_IRQ_EN
    wr(32'd13, 32'h1, 4'h1, we);
    wr(32'd11, 32'h1, 4'h1, we);
    i_ack[1] = 1'b1;
    i_done[1] = 1'b1;
    i_result[63:32] = 32'd9;
    tick();
    i_ack[1] = 1'b0;
    i_done[1] = 1'b0;
    rd(32'd12, d, e);
    check("irq_ch1_done", 64'(d), 64'h1);
    check("irq_not_yet", 64'(o_irq), 64'h0);
    tick();
    check("irq_rise", 64'(o_irq), 64'h1);
    wr(32'd3, 32'h1, 4'h1, we);
    i_ack[0] = 1'b1;
    i_done[0] = 1'b1;
    i_result[31:0] = 32'd4;
    wr(32'd12, 32'h1, 4'h1, we);
    i_ack[0] = 1'b0;
    i_done[0] = 1'b0;
    check("irq_hold_a", 64'(o_irq), 64'h1);
    tick();
    check("irq_hold_b", 64'(o_irq), 64'h1);
    wr(32'd4, 32'h1, 4'h1, we);
    check("irq_hold_c", 64'(o_irq), 64'h1);
    tick();
    check("irq_fall", 64'(o_irq), 64'h0);
`endif

    // Channel 0: done without ack ignored, then ack+done together.
    rd(32'd4, d, e);
    check("ch0_status_pre", 64'(d), 64'h0);
    i_result[31:0] = 32'h99;
    i_done[0] = 1'b1;
    tick();
    i_done[0] = 1'b0;
    rd(32'd4, d, e);
    check("ch0_idle_done_ign", 64'(d), 64'h0);
    wr(32'd3, 32'h3, 4'h1, we);
    i_done[0] = 1'b1;
    i_result[31:0] = 32'h12;
    tick();
    check("ch0_req_done_noack", 64'(o_start[0]), 64'h1);
    rd(32'd4, d, e);
    check("ch0_req_status", 64'(d), 64'h0);
    i_ack[0] = 1'b1;
    i_result[31:0] = 32'h34;
    tick();
    i_ack[0] = 1'b0;
    i_done[0] = 1'b0;
    check("ch0_start_drop", 64'(o_start[0]), 64'h0);
    rd(32'd3, d, e);
    check("ch0_ctrl_direct_idle", 64'(d), 64'h2);
    rd(32'd2, d, e);
    check("ch0_res", 64'(d), 64'h34);
    rd(32'd4, d, e);
    check("ch0_status", 64'(d), 64'h1);

    // Reset while channel 1 is in REQ aborts it.
    wr(32'd11, 32'h1, 4'h1, we);
    check("rst_req_start", 64'(o_start[1]), 64'h1);
    ARST = 1'b1;
    tick();
    check("rst_start_drop", 64'(o_start), 64'h0);
    ARST = 1'b0;
    i_done[1] = 1'b1;
    i_result[63:32] = 32'h55;
    tick();
    i_done[1] = 1'b0;
    rd(32'd11, d, e);
    check("rst_ctrl_idle", 64'(d), 64'h0);
    rd(32'd12, d, e);
    check("rst_late_done_status", 64'(d), 64'h0);
    rd(32'd10, d, e);
    check("rst_late_done_res", 64'(d), 64'h0);
    check("rst_irq", 64'(o_irq), 64'h0);
    check("rst_r0", 64'(o_r0[31:0]), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
